demux_memoria1x2_4bits: RTL and testbench
=========================================

// Module: demux_memoria1x2_4bits
// PURPOSE
//  Receiving end of the 2x1 valid-qualified mux path: takes one registered WIDTH-bit stream with valid,
//  steers each accepted word to lane 0 or lane 1 per selector, and buffers it in a per-lane FIFO.
//  Each lane drains independently over a valid/ready handshake; a full lane back-pressures the input.
//  Sits between the mux output stage and two downstream consumers.
// PARAMETERS
//  WIDTH    4  data word width in bits
//  DEPTH    2  entries per lane FIFO (power of two, >=2)
//  CNT_W    8  width of per-lane accepted-word counters (wrap-around)
// PORTS
//  clk            in   1        rising-edge clock
//  reset          in   1        synchronous, active-high reset
//  selector       in   1        lane select for the current input word: 0 -> lane 0, 1 -> lane 1
//  valid_input    in   1        data_in holds a valid word
//  data_in        in   WIDTH    input word
//  ready_input    out  1        block can accept a word on the selected lane this cycle
//  data_out0      out  WIDTH    lane 0 head-of-FIFO word
//  valid_out0     out  1        lane 0 FIFO non-empty
//  ready_out0     in   1        lane 0 consumer takes data_out0 this cycle
//  data_out1      out  WIDTH    lane 1 head-of-FIFO word
//  valid_out1     out  1        lane 1 FIFO non-empty
//  ready_out1     in   1        lane 1 consumer takes data_out1 this cycle
//  count0         out  CNT_W    words accepted into lane 0 since reset
//  count1         out  CNT_W    words accepted into lane 1 since reset
// BEHAVIOUR
//  - Reset (reset=1 at posedge): both FIFOs emptied (pointers/occupancy 0), valid_out0/1=0,
//    data_out0/1=0, count0/1=0. Reset takes priority over any push/pop in the same cycle;
//    words in flight are discarded.
//  - ready_input = ~reset & (occupancy of lane[selector] < DEPTH); combinational from selector
//    and registered occupancy only (no path from valid_input or ready_out*).
//  - Push: valid_input & ready_input at posedge -> data_in written to tail of lane[selector];
//    that lane's occupancy +1 and count +1. Other lane unaffected.
//  - Pop lane n: valid_outn & ready_outn at posedge -> head advances, occupancy -1.
//    ready_outn while valid_outn=0 is ignored.
//  - Push and pop on the same lane in one cycle: occupancy unchanged, order preserved.
//    Push to a full lane is impossible (ready_input=0) even if that lane pops the same cycle.
//  - Latency: word pushed at edge k appears on data_outn/valid_outn after edge k when lane was
//    empty (1-cycle, no combinational bypass from data_in to data_out).
//  - data_outn/valid_outn come from registered FIFO state; data_outn holds the head word stable
//    while valid_outn=1 and ready_outn=0. When a lane is empty, data_outn holds 0.
//  - FIFO order strict per lane; no reordering across lanes is defined (lanes independent).
//  - Pointers wrap modulo DEPTH; occupancy range 0..DEPTH.
//  - count0/1 wrap from 2^CNT_W-1 to 0 silently.
//  - valid_input=0: nothing pushed; selector/data_in are don't-care.
// TESTING
//  1 reset=1 two cycles with valid_input=1 -> no push; all outputs 0; ready_input=0 during reset.
//  2 sel=0, push 0xA then sel=1 push 0x5, ready_out*=0 -> next cycle data_out0=0xA valid_out0=1,
//    data_out1=0x5 valid_out1=1, count0=1 count1=1.
//  3 sel=0, push 0x1,0x2 with ready_out0=0 -> ready_input=0 on sel=0, ready_input=1 on sel=1;
//    then ready_out0=1 one cycle -> data_out0 goes 0x1 -> 0x2, ready_input returns 1.
//  4 lane 0 holds one word, push 0x3 and pop same cycle -> occupancy stays 1, data_out0=0x3 next.
//  5 256 pushes to lane 1 with ready_out1=1 -> count1 wraps to 0; data order 0..F repeating intact.
//  6 reset asserted with both lanes full -> next cycle valid_out0/1=0, ready_input=1, counts 0.

Source files
------------

// File: rtl/demux_memoria1x2_4bits.sv
// -----------------------------------------------------------------------------
// demux_memoria1x2_4bits
//   Receiving end of the valid-qualified 2x1 mux path. Each accepted input word
//   is steered to lane 0 or lane 1 by `selector` and buffered in that lane's
//   FIFO. The two lanes drain independently over valid/ready handshakes, and a
//   full lane back-pressures the input through `ready_input`.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   selector     in   lane select for the current word (0 -> lane 0, 1 -> lane 1)
//   valid_input  in   data_in holds a valid word
//   data_in      in   WIDTH-bit input word
//   ready_input  out  selected lane can accept a word this cycle
//   data_out0/1  out  head-of-FIFO word for lane 0/1 (0 when the lane is empty)
//   valid_out0/1 out  lane 0/1 FIFO non-empty
//   ready_out0/1 in   lane 0/1 consumer takes the head word this cycle
//   count0/1     out  words accepted into lane 0/1 since reset (wrap-around)
// -----------------------------------------------------------------------------
module demux_memoria1x2_4bits #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             selector,
  input  logic             valid_input,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_input,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  input  logic             ready_out0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  input  logic             ready_out1,
  output logic [CNT_W-1:0] count0,
  output logic [CNT_W-1:0] count1
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Lane storage is pure data and carries no reset; emptiness is tracked by
  // the occupancy counters, and the output mux forces 0 on an empty lane.
  logic [WIDTH-1:0] mem_q    [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [OCC_W-1:0] occ_q    [2];
  logic [OCC_W-1:0] occ_d    [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] ready_out;

  assign ready_out = {ready_out1, ready_out0};

  // Depends only on selector, reset and registered occupancy, so a lane that
  // is full but popping this cycle still refuses the push.
  assign ready_input = ~reset & (occ_q[selector] < OCC_W'(DEPTH));

  // ---- next-state: per-lane push/pop decode ----
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      push[n]     = valid_input & ready_input & (int'(selector) == n);
      pop[n]      = (occ_q[n] != '0) & ready_out[n];
      // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
      wr_ptr_d[n] = push[n] ? wr_ptr_q[n] + PTR_W'(1) : wr_ptr_q[n];
      rd_ptr_d[n] = pop[n]  ? rd_ptr_q[n] + PTR_W'(1) : rd_ptr_q[n];
      cnt_d[n]    = push[n] ? cnt_q[n] + CNT_W'(1)    : cnt_q[n];
      if (push[n] && !pop[n]) begin
        occ_d[n] = occ_q[n] + OCC_W'(1);
      end else if (pop[n] && !push[n]) begin
        occ_d[n] = occ_q[n] - OCC_W'(1);
      end else begin
        occ_d[n] = occ_q[n];
      end
    end
  end

  // ---- registered state: control with reset, storage without ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        occ_q[n]    <= '0;
        cnt_q[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        occ_q[n]    <= occ_d[n];
        cnt_q[n]    <= cnt_d[n];
      end
    end
  end

  // push is already forced low during reset through ready_input.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        mem_q[n][wr_ptr_q[n]] <= data_in;
      end
    end
  end

  // ---- outputs from registered FIFO state ----
  assign valid_out0 = (occ_q[0] != '0);
  assign valid_out1 = (occ_q[1] != '0);
  assign data_out0  = valid_out0 ? mem_q[0][rd_ptr_q[0]] : '0;
  assign data_out1  = valid_out1 ? mem_q[1][rd_ptr_q[1]] : '0;
  assign count0     = cnt_q[0];
  assign count1     = cnt_q[1];

endmodule

// File: tb/tb_demux_memoria1x2_4bits.sv
module tb_demux_memoria1x2_4bits;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             selector;
  logic             valid_input;
  logic [WIDTH-1:0] data_in;
  logic             ready_input;
  logic [WIDTH-1:0] data_out0;
  logic             valid_out0;
  logic             ready_out0;
  logic [WIDTH-1:0] data_out1;
  logic             valid_out1;
  logic             ready_out1;
  logic [CNT_W-1:0] count0;
  logic [CNT_W-1:0] count1;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected words per lane plus model counters.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] mcnt0;
  logic [CNT_W-1:0] mcnt1;
  bit               armed = 0;

  demux_memoria1x2_4bits #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .selector(selector), .valid_input(valid_input),
    .data_in(data_in), .ready_input(ready_input),
    .data_out0(data_out0), .valid_out0(valid_out0), .ready_out0(ready_out0),
    .data_out1(data_out1), .valid_out1(valid_out1), .ready_out1(ready_out1),
    .count0(count0), .count1(count1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Scoreboard sample, taken on the falling edge with inputs stable.
  task automatic sb_sample();
    logic             exp_rdy;
    logic             ev0, ev1;
    logic [WIDTH-1:0] ed0, ed1;
    if (reset) begin
      q0.delete(); q1.delete();
      mcnt0 = '0; mcnt1 = '0;
      armed = 1;
      checks++;
      if (ready_input !== 1'b0) begin
        failures++; $display("FAIL sb_ready_in_reset: got %b expected 0", ready_input);
      end
    end else if (armed) begin
      exp_rdy = (selector ? q1.size() : q0.size()) < DEPTH;
      ev0 = (q0.size() != 0);
      ev1 = (q1.size() != 0);
      ed0 = ev0 ? q0[0] : '0;
      ed1 = ev1 ? q1[0] : '0;
      checks += 7;
      if (ready_input !== exp_rdy) begin
        failures++; $display("FAIL sb_ready_input: got %b expected %b", ready_input, exp_rdy);
      end
      if (valid_out0 !== ev0) begin
        failures++; $display("FAIL sb_valid_out0: got %b expected %b", valid_out0, ev0);
      end
      if (valid_out1 !== ev1) begin
        failures++; $display("FAIL sb_valid_out1: got %b expected %b", valid_out1, ev1);
      end
      if (data_out0 !== ed0) begin
        failures++; $display("FAIL sb_data_out0: got %h expected %h", data_out0, ed0);
      end
      if (data_out1 !== ed1) begin
        failures++; $display("FAIL sb_data_out1: got %h expected %h", data_out1, ed1);
      end
      if (count0 !== mcnt0) begin
        failures++; $display("FAIL sb_count0: got %0d expected %0d", count0, mcnt0);
      end
      if (count1 !== mcnt1) begin
        failures++; $display("FAIL sb_count1: got %0d expected %0d", count1, mcnt1);
      end
      if (ev0 && ready_out0) void'(q0.pop_front());
      if (ev1 && ready_out1) void'(q1.pop_front());
      if (valid_input && exp_rdy) begin
        if (selector) begin q1.push_back(data_in); mcnt1 = mcnt1 + 1'b1; end
        else          begin q0.push_back(data_in); mcnt0 = mcnt0 + 1'b1; end
      end
    end
  endtask

  // Drive one cycle of inputs, sample the scoreboard, return 1 time unit after the edge.
  task automatic drive(input logic rst, input logic sel, input logic vin,
                       input logic [WIDTH-1:0] din, input logic r0, input logic r1);
    reset = rst; selector = sel; valid_input = vin; data_in = din;
    ready_out0 = r0; ready_out1 = r1;
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 1, 4'hF, 0, 0);
    checks++;
    if (ready_input !== 1'b0) begin
      failures++; $display("FAIL reset_ready_during: got %b expected 0", ready_input);
    end
    drive(1, 1, 1, 4'hE, 1, 1);
    reset = 0; valid_input = 0; selector = 0; #1;
    checks += 5;
    if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b%b expected 00", valid_out1, valid_out0);
    end
    if (data_out0 !== 4'h0 || data_out1 !== 4'h0) begin
      failures++; $display("FAIL reset_data: got %h %h expected 0 0", data_out0, data_out1);
    end
    if (count0 !== 8'd0) begin
      failures++; $display("FAIL reset_count0: got %0d expected 0", count0);
    end
    if (count1 !== 8'd0) begin
      failures++; $display("FAIL reset_count1: got %0d expected 0", count1);
    end
    if (ready_input !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after: got %b expected 1", ready_input);
    end
  endtask

  task automatic test_basic();
    drive(0, 0, 1, 4'hA, 0, 0);
    checks += 2;
    if (valid_out0 !== 1'b1 || data_out0 !== 4'hA) begin
      failures++; $display("FAIL basic_latency0: got v=%b d=%h expected v=1 d=a", valid_out0, data_out0);
    end
    if (valid_out1 !== 1'b0) begin
      failures++; $display("FAIL basic_lane1_idle: got %b expected 0", valid_out1);
    end
    drive(0, 1, 1, 4'h5, 0, 0);
    checks += 4;
    if (valid_out0 !== 1'b1 || data_out0 !== 4'hA) begin
      failures++; $display("FAIL basic_lane0: got v=%b d=%h expected v=1 d=a", valid_out0, data_out0);
    end
    if (valid_out1 !== 1'b1 || data_out1 !== 4'h5) begin
      failures++; $display("FAIL basic_lane1: got v=%b d=%h expected v=1 d=5", valid_out1, data_out1);
    end
    if (count0 !== 8'd1) begin
      failures++; $display("FAIL basic_count0: got %0d expected 1", count0);
    end
    if (count1 !== 8'd1) begin
      failures++; $display("FAIL basic_count1: got %0d expected 1", count1);
    end
    drive(0, 0, 0, 4'h0, 1, 1);
    checks++;
    if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0 || data_out0 !== 4'h0 || data_out1 !== 4'h0) begin
      failures++; $display("FAIL basic_drain: got v=%b%b d=%h%h expected v=00 d=00",
                           valid_out1, valid_out0, data_out1, data_out0);
    end
  endtask

  task automatic test_backpressure();
    drive(0, 0, 1, 4'h1, 0, 0);
    drive(0, 0, 1, 4'h2, 0, 0);
    valid_input = 0; selector = 0; #1;
    checks++;
    if (ready_input !== 1'b0) begin
      failures++; $display("FAIL bp_full_lane0: got %b expected 0", ready_input);
    end
    selector = 1; #1;
    checks++;
    if (ready_input !== 1'b1) begin
      failures++; $display("FAIL bp_free_lane1: got %b expected 1", ready_input);
    end
    drive(0, 0, 0, 4'h0, 1, 0);
    checks += 2;
    if (valid_out0 !== 1'b1 || data_out0 !== 4'h2) begin
      failures++; $display("FAIL bp_pop_next: got v=%b d=%h expected v=1 d=2", valid_out0, data_out0);
    end
    if (ready_input !== 1'b1) begin
      failures++; $display("FAIL bp_ready_back: got %b expected 1", ready_input);
    end
    drive(0, 0, 0, 4'h0, 1, 0);
    checks++;
    if (valid_out0 !== 1'b0) begin
      failures++; $display("FAIL bp_drain: got %b expected 0", valid_out0);
    end
  endtask

  task automatic test_push_pop();
    drive(0, 0, 1, 4'h7, 0, 0);
    drive(0, 0, 1, 4'h3, 1, 0);
    checks += 2;
    if (valid_out0 !== 1'b1 || data_out0 !== 4'h3) begin
      failures++; $display("FAIL pp_same_cycle: got v=%b d=%h expected v=1 d=3", valid_out0, data_out0);
    end
    if (ready_input !== 1'b1) begin
      failures++; $display("FAIL pp_occ_one: got %b expected 1", ready_input);
    end
    drive(0, 0, 1, 4'h4, 0, 0);
    // Lane full and popping: 0x9 must be refused.
    drive(0, 0, 1, 4'h9, 1, 0);
    checks++;
    if (data_out0 !== 4'h4) begin
      failures++; $display("FAIL pp_full_pop: got %h expected 4", data_out0);
    end
    drive(0, 0, 0, 4'h0, 1, 0);
    checks += 2;
    if (valid_out0 !== 1'b0) begin
      failures++; $display("FAIL pp_no_push_on_full: got %b expected 0", valid_out0);
    end
    if (count0 !== 8'd6) begin
      failures++; $display("FAIL pp_count0: got %0d expected 6", count0);
    end
  endtask

  task automatic test_wrap();
    drive(1, 0, 0, 4'h0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 1, 4'(i), 0, 1);
      if (i == 254) begin
        checks++;
        if (count1 !== 8'd255) begin
          failures++; $display("FAIL wrap_count_255: got %0d expected 255", count1);
        end
      end
    end
    checks += 2;
    if (count1 !== 8'd0) begin
      failures++; $display("FAIL wrap_count_0: got %0d expected 0", count1);
    end
    if (data_out1 !== 4'hF) begin
      failures++; $display("FAIL wrap_last_word: got %h expected f", data_out1);
    end
    drive(0, 0, 0, 4'h0, 0, 1);
    checks++;
    if (valid_out1 !== 1'b0) begin
      failures++; $display("FAIL wrap_drain: got %b expected 0", valid_out1);
    end
  endtask

  task automatic test_reset_full();
    drive(0, 0, 1, 4'h1, 0, 0);
    drive(0, 0, 1, 4'h2, 0, 0);
    drive(0, 1, 1, 4'h3, 0, 0);
    drive(0, 1, 1, 4'h4, 0, 0);
    checks += 2;
    if (valid_out0 !== 1'b1 || valid_out1 !== 1'b1) begin
      failures++; $display("FAIL rf_filled: got %b%b expected 11", valid_out1, valid_out0);
    end
    if (ready_input !== 1'b0) begin
      failures++; $display("FAIL rf_full_ready: got %b expected 0", ready_input);
    end
    drive(1, 0, 1, 4'hF, 1, 1);
    reset = 0; valid_input = 0; ready_out0 = 0; ready_out1 = 0; #1;
    checks += 4;
    if (valid_out0 !== 1'b0 || valid_out1 !== 1'b0) begin
      failures++; $display("FAIL rf_valid: got %b%b expected 00", valid_out1, valid_out0);
    end
    if (data_out0 !== 4'h0 || data_out1 !== 4'h0) begin
      failures++; $display("FAIL rf_data: got %h %h expected 0 0", data_out0, data_out1);
    end
    if (ready_input !== 1'b1) begin
      failures++; $display("FAIL rf_ready: got %b expected 1", ready_input);
    end
    if (count0 !== 8'd0 || count1 !== 8'd0) begin
      failures++; $display("FAIL rf_counts: got %0d %0d expected 0 0", count0, count1);
    end
    drive(0, 0, 0, 4'h0, 0, 0);
  endtask

  initial begin
    reset = 1; selector = 0; valid_input = 0; data_in = '0;
    ready_out0 = 0; ready_out1 = 0;
    mcnt0 = '0; mcnt1 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_push_pop();
    test_wrap();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
